// File: rtl/tile_buffer.sv
// Double-buffered operand tile store: one bank fills while the other streams out as a skewed wavefront.
// Optional transpose read order is enabled by defining TB_TRANSPOSE_EN.
module tile_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int LINES      = 4,
   parameter int DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [((LINES > 1) ? $clog2(LINES) : 1)-1:0] wr_line,
   input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_elem,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        commit,
   output logic                        fill_ready,
   input  logic                        start,
   output logic                        start_ready,
   output logic                        busy,
   output logic                        done,
   output logic [LINES-1:0]            out_valid,
   output logic [DATA_WIDTH*LINES-1:0] data_out
`ifdef TB_TRANSPOSE_EN
   ,
   input  logic                        transpose
`endif
);

   localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int EW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int T  = DEPTH + LINES - 1;
   localparam int TW = (T > 1) ? $clog2(T) : 1;

   localparam logic [1:0] EMPTY  = 2'd0;
   localparam logic [1:0] FULL   = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

`ifdef TB_TRANSPOSE_EN
   if (LINES != DEPTH) begin : g_bad_transpose
      $error("tile_buffer: transpose requires LINES == DEPTH");
   end
`endif

   logic [DATA_WIDTH-1:0]       mem [2][LINES][DEPTH];
   logic [1:0]                  bank_st [2];
   logic                        fill_ptr, rd_ptr;
   logic                        streaming;
   logic [TW-1:0]               t;
   logic                        last, start_acc, commit_acc, wr_ok, start_bank;
   logic                        beat_en, beat_bank, beat_tr;
   logic [TW-1:0]               beat_t;
   logic [LINES-1:0]            beat_valid;
   logic [DATA_WIDTH*LINES-1:0] beat_data;

   assign fill_ready  = (bank_st[fill_ptr] == EMPTY);
   assign last        = streaming && (t == TW'(T - 1));
   assign start_ready = (!streaming && bank_st[rd_ptr] == FULL) ||
                        (last && bank_st[~rd_ptr] == FULL);
   assign start_acc   = start && start_ready;
   assign commit_acc  = commit && fill_ready;
   // Widened compares keep the range check meaningful when LINES/DEPTH are not powers of two.
   assign wr_ok       = wr_en && fill_ready &&
                        ({1'b0, wr_line} < (LW + 1)'(LINES)) &&
                        ({1'b0, wr_elem} < (EW + 1)'(DEPTH));
   assign start_bank  = streaming ? ~rd_ptr : rd_ptr;

   assign busy = streaming;
   assign done = last;

   // A start always presents beat 0 of the newly started bank; otherwise advance the current stream.
   assign beat_en   = start_acc || (streaming && !last);
   assign beat_bank = start_acc ? start_bank : rd_ptr;
   assign beat_t    = start_acc ? '0 : t + TW'(1);

`ifdef TB_TRANSPOSE_EN
   logic tr_q;
   assign beat_tr = start_acc ? transpose : tr_q;
`else
   assign beat_tr = 1'b0;
`endif

   always_comb begin
      int e;
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      e          = 0;
      beat_valid = '0;
      beat_data  = '0;
      for (int l = 0; l < LINES; l++) begin
         e = int'(beat_t) - l;
         if (beat_en && e >= 0 && e < DEPTH) begin
            beat_valid[l] = 1'b1;
            if (beat_tr)
               beat_data[DATA_WIDTH*l +: DATA_WIDTH] = mem[beat_bank][LW'(e)][EW'(l)];
            else
               beat_data[DATA_WIDTH*l +: DATA_WIDTH] = mem[beat_bank][LW'(l)][EW'(e)];
         end
      end
   end

   // NOTE: tile storage carries no reset; bank state guards every read, so stale contents never escape.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[fill_ptr][wr_line][wr_elem] <= wr_data;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_st[0] <= EMPTY;
         bank_st[1] <= EMPTY;
         fill_ptr   <= 1'b0;
         rd_ptr     <= 1'b0;
         streaming  <= 1'b0;
         t          <= '0;
         out_valid  <= '0;
         data_out   <= '0;
      end else begin
         if (commit_acc) begin
            bank_st[fill_ptr] <= FULL;
            fill_ptr          <= ~fill_ptr;
         end
         if (last) begin
            bank_st[rd_ptr] <= EMPTY;
            rd_ptr          <= ~rd_ptr;
         end
         if (start_acc) begin
            bank_st[start_bank] <= ACTIVE;
            streaming           <= 1'b1;
            t                   <= '0;
         end else if (last) begin
            streaming <= 1'b0;
            t         <= '0;
         end else if (streaming) begin
            t <= t + TW'(1);
         end
         out_valid <= beat_valid;
         data_out  <= beat_data;
      end
   end

`ifdef TB_TRANSPOSE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tr_q <= 1'b0;
      else if (start_acc)
         tr_q <= transpose;
   end
`endif

endmodule

// File: tb/tb_tile_buffer.sv
// Directed, table-driven bench for tile_buffer (DATA_WIDTH=8, LINES=DEPTH=4, T=7).
module tb_tile_buffer;

   localparam int T = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [1:0]  wr_line;
   logic [1:0]  wr_elem;
   logic [7:0]  wr_data;
   logic        commit;
   logic        fill_ready;
   logic        start;
   logic        start_ready;
   logic        busy;
   logic        done;
   logic [3:0]  out_valid;
   logic [31:0] data_out;
`ifdef TB_TRANSPOSE_EN
   logic        transpose = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic        done;
   } beat_rec_t;

   beat_rec_t tbl [T];

   tile_buffer #(.DATA_WIDTH(8), .LINES(4), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_line     (wr_line),
      .wr_elem     (wr_elem),
      .wr_data     (wr_data),
      .commit      (commit),
      .fill_ready  (fill_ready),
      .start       (start),
      .start_ready (start_ready),
      .busy        (busy),
      .done        (done),
      .out_valid   (out_valid),
      .data_out    (data_out)
`ifdef TB_TRANSPOSE_EN
      ,
      .transpose   (transpose)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_elem(input int l, input int e, input logic [7:0] d, input logic cmt);
      wr_en   = 1'b1;
      wr_line = 2'(l);
      wr_elem = 2'(e);
      wr_data = d;
      commit  = cmt;
      tick();
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   // Tile value is base + 0x10*line + elem; skip_last leaves (3,3) for a separate write.
   task automatic write_tile(input logic [7:0] base, input bit skip_last);
      for (int l = 0; l < 4; l++)
         for (int e = 0; e < 4; e++)
            if (!(skip_last && l == 3 && e == 3))
               write_elem(l, e, base + 8'(16 * l + e), 1'b0);
   endtask

   task automatic commit_pulse();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   task automatic stream_check(input string name, input logic [7:0] base, input bit allow_wait);
      logic [31:0] exp;
      int waited;
      waited = 0;
      if (allow_wait)
         while (!busy && waited < 4) begin
            tick();
            waited++;
         end
      for (int b = 0; b < T; b++) begin
         exp = tbl[b].data;
         for (int l = 0; l < 4; l++)
            if (tbl[b].valid[l]) exp[8*l +: 8] = exp[8*l +: 8] + base;
         check($sformatf("%s_b%0d_busy", name, b), 32'(busy), 32'd1);
         check($sformatf("%s_b%0d_valid", name, b), 32'(out_valid), 32'(tbl[b].valid));
         check($sformatf("%s_b%0d_data", name, b), data_out, exp);
         check($sformatf("%s_b%0d_done", name, b), 32'(done), 32'(tbl[b].done));
         tick();
      end
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_done"}, 32'(done), 32'd0);
      check({name, "_valid"}, 32'(out_valid), 32'd0);
      check({name, "_data"}, data_out, 32'd0);
   endtask

   initial begin
      bit seen_busy;
      tbl[0] = '{4'b0001, 32'h00000000, 1'b0};
      tbl[1] = '{4'b0011, 32'h00001001, 1'b0};
      tbl[2] = '{4'b0111, 32'h00201102, 1'b0};
      tbl[3] = '{4'b1111, 32'h30211203, 1'b0};
      tbl[4] = '{4'b1110, 32'h31221300, 1'b0};
      tbl[5] = '{4'b1100, 32'h32230000, 1'b0};
      tbl[6] = '{4'b1000, 32'h33000000, 1'b1};

      rst = 1'b1; wr_en = 1'b0; wr_line = '0; wr_elem = '0; wr_data = '0;
      commit = 1'b0; start = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check_idle("reset");
      check("reset_fill_ready", 32'(fill_ready), 32'd1);
      check("reset_start_ready", 32'(start_ready), 32'd0);

      // Basic fill, commit, single stream; bank1 stays fillable.
      write_tile(8'h00, 1'b0);
      commit_pulse();
      check("t2_fill_ready", 32'(fill_ready), 32'd1);
      check("t2_start_ready", 32'(start_ready), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      stream_check("t2", 8'h00, 1'b1);
      check_idle("t2_after");

      // Two committed tiles block the fill side; an extra write+commit is dropped.
      write_tile(8'h00, 1'b0);
      commit_pulse();
      write_tile(8'h80, 1'b0);
      commit_pulse();
      check("t3_fill_ready_full", 32'(fill_ready), 32'd0);
      write_elem(0, 0, 8'hEE, 1'b1);
      check("t3_fill_ready_ignored", 32'(fill_ready), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      stream_check("t3", 8'h00, 1'b1);
      check("t3_fill_ready_freed", 32'(fill_ready), 32'd1);

      // Back-to-back streams with start held: no bubble between tiles.
      write_tile(8'h40, 1'b0);
      commit_pulse();
      start = 1'b1;
      tick();
      stream_check("t4a", 8'h80, 1'b1);
      stream_check("t4b", 8'h40, 1'b0);
      start = 1'b0;
      check_idle("t4_after");
      check("t4_start_ready", 32'(start_ready), 32'd0);

      // Write landing in the same cycle as commit must be part of the tile.
      write_tile(8'h00, 1'b1);
      write_elem(3, 3, 8'h33, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      stream_check("t5", 8'h00, 1'b1);

      // Start with no FULL bank produces nothing.
      seen_busy = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen_busy |= (busy | (|out_valid));
      end
      start = 1'b0;
      check("t5_no_tile_busy", 32'(seen_busy), 32'd0);

      // Asynchronous reset mid-stream.
      write_tile(8'h00, 1'b0);
      commit_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      check("t1_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_idle("t1_rst");
      check("t1_fill_ready", 32'(fill_ready), 32'd1);
      check("t1_start_ready", 32'(start_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check_idle("t1_post");
      check("t1_post_start_ready", 32'(start_ready), 32'd0);

`ifdef TB_TRANSPOSE_EN
      begin
         int waited;
         write_tile(8'h00, 1'b0);
         commit_pulse();
         transpose = 1'b1;
         start = 1'b1;
         tick();
         start = 1'b0;
         transpose = 1'b0;
         waited = 0;
         while (!busy && waited < 4) begin
            tick();
            waited++;
         end
         tick();
         check("t6_b1_valid", 32'(out_valid), 32'h3);
         check("t6_b1_data", data_out, 32'h00000110);
         tick(); tick();
         check("t6_b3_valid", 32'(out_valid), 32'hF);
         check("t6_b3_data", data_out, 32'h03122130);
         waited = 0;
         while (busy && waited < 10) begin
            tick();
            waited++;
         end
         check_idle("t6_after");
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
